// File: rtl/rs_age_issue_queue_if.sv
// Dispatch, issue and result-broadcast buses of the age-ordered reservation station.
interface rs_age_issue_queue_if #(
  parameter int ROB_W     = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int CDB_PORTS = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [OP_W-1:0]             in_optype;
  logic [DATA_W-1:0]           in_pc;
  logic [ROB_W-1:0]            in_rd_alias;
  logic [ROB_W-1:0]            in_Qi;
  logic [ROB_W-1:0]            in_Qj;
  logic [DATA_W-1:0]           in_Vi;
  logic [DATA_W-1:0]           in_Vj;
  logic [DATA_W-1:0]           in_imm;

  logic                        out_valid;
  logic                        out_ready;
  logic [OP_W-1:0]             out_optype;
  logic [ROB_W-1:0]            out_rd;
  logic [DATA_W-1:0]           out_pc;
  logic [DATA_W-1:0]           out_Vi;
  logic [DATA_W-1:0]           out_Vj;
  logic [DATA_W-1:0]           out_imm;

  logic [CDB_PORTS-1:0]        cdb_valid;
  logic [CDB_PORTS*ROB_W-1:0]  cdb_alias;
  logic [CDB_PORTS*DATA_W-1:0] cdb_data;

  modport master (
    output in_valid, in_optype, in_pc, in_rd_alias, in_Qi, in_Qj, in_Vi, in_Vj, in_imm,
    input  in_ready,
    input  out_valid, out_optype, out_rd, out_pc, out_Vi, out_Vj, out_imm,
    output out_ready,
    output cdb_valid, cdb_alias, cdb_data
  );

  modport slave (
    input  in_valid, in_optype, in_pc, in_rd_alias, in_Qi, in_Qj, in_Vi, in_Vj, in_imm,
    output in_ready,
    output out_valid, out_optype, out_rd, out_pc, out_Vi, out_Vj, out_imm,
    input  out_ready,
    input  cdb_valid, cdb_alias, cdb_data
  );
endinterface

// File: rtl/rs_age_issue_queue.sv
// Reservation station: CDB wakeup of renamed operands, oldest-ready issue via an age matrix.
module rs_age_wake #(
  parameter int ROB_W     = 4,
  parameter int DATA_W    = 32,
  parameter int CDB_PORTS = 2
) (
  input  logic [ROB_W-1:0]            q_i,
  input  logic [DATA_W-1:0]           v_i,
  input  logic [CDB_PORTS-1:0]        cdb_valid_i,
  input  logic [CDB_PORTS*ROB_W-1:0]  cdb_alias_i,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data_i,
  output logic [ROB_W-1:0]            q_o,
  output logic [DATA_W-1:0]           v_o
);
  // Descending scan so the lowest matching port overrides higher ones.
  always_comb begin
    q_o = q_i;
    v_o = v_i;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (q_i != '0 && cdb_valid_i[p] && cdb_alias_i[p*ROB_W +: ROB_W] == q_i) begin
        q_o = '0;
        v_o = cdb_data_i[p*DATA_W +: DATA_W];
      end
    end
  end
endmodule

module rs_age_issue_queue #(
  parameter int RS_DEPTH  = 16,
  parameter int IDX_W     = $clog2(RS_DEPTH)+1,
  parameter int ROB_W     = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int CDB_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback_signal,
  rs_age_issue_queue_if.slave  bus,
  output logic [IDX_W-1:0]     count
);
  localparam int              SEL_W  = $clog2(RS_DEPTH);
  localparam logic [OP_W-1:0] OP_NOP = '0;

  logic [RS_DEPTH-1:0]                busy_q, busy_d;
  logic [RS_DEPTH-1:0][OP_W-1:0]      op_q;
  logic [RS_DEPTH-1:0][DATA_W-1:0]    pc_q, vi_q, vj_q, imm_q;
  logic [RS_DEPTH-1:0][ROB_W-1:0]     rd_q, qi_q, qj_q;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older_q;
  logic [IDX_W-1:0]                   count_q, count_d;

  logic              out_valid_q;
  logic [OP_W-1:0]   out_op_q;
  logic [ROB_W-1:0]  out_rd_q;
  logic [DATA_W-1:0] out_pc_q, out_vi_q, out_vj_q, out_imm_q;

  logic [RS_DEPTH-1:0][ROB_W-1:0]  wqi, wqj;
  logic [RS_DEPTH-1:0][DATA_W-1:0] wvi, wvj;
  logic [ROB_W-1:0]                dqi, dqj;
  logic [DATA_W-1:0]               dvi, dvj;

  logic [RS_DEPTH-1:0] rdy_vec, sel_oh, free_oh;
  logic [SEL_W-1:0]    sel_idx, free_idx;
  logic                take, issue, alloc;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ent
    rs_age_wake #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)) u_wi (
      .q_i(qi_q[g]), .v_i(vi_q[g]), .cdb_valid_i(bus.cdb_valid), .cdb_alias_i(bus.cdb_alias),
      .cdb_data_i(bus.cdb_data), .q_o(wqi[g]), .v_o(wvi[g]));
    rs_age_wake #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)) u_wj (
      .q_i(qj_q[g]), .v_i(vj_q[g]), .cdb_valid_i(bus.cdb_valid), .cdb_alias_i(bus.cdb_alias),
      .cdb_data_i(bus.cdb_data), .q_o(wqj[g]), .v_o(wvj[g]));
  end

  // Dispatch-time bypass: an operand produced this very cycle is captured on entry.
  rs_age_wake #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)) u_di (
    .q_i(bus.in_Qi), .v_i(bus.in_Vi), .cdb_valid_i(bus.cdb_valid), .cdb_alias_i(bus.cdb_alias),
    .cdb_data_i(bus.cdb_data), .q_o(dqi), .v_o(dvi));
  rs_age_wake #(.ROB_W(ROB_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)) u_dj (
    .q_i(bus.in_Qj), .v_i(bus.in_Vj), .cdb_valid_i(bus.cdb_valid), .cdb_alias_i(bus.cdb_alias),
    .cdb_data_i(bus.cdb_data), .q_o(dqj), .v_o(dvj));

  // An entry is selected when no other ready entry is older than it.
  always_comb begin
    rdy_vec  = '0;
    sel_oh   = '0;
    sel_idx  = '0;
    free_idx = '0;
    free_oh  = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      rdy_vec[i] = busy_q[i] && qi_q[i] == '0 && qj_q[i] == '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      sel_oh[i] = rdy_vec[i];
      for (int j = 0; j < RS_DEPTH; j++)
        if (rdy_vec[j] && older_q[j][i]) sel_oh[i] = 1'b0;
      if (sel_oh[i]) sel_idx = SEL_W'(i);
    end
    for (int i = RS_DEPTH-1; i >= 0; i--)
      if (!busy_q[i]) free_idx = SEL_W'(i);
    free_oh[free_idx] = 1'b1;
  end

  assign bus.in_ready = count_q < IDX_W'(RS_DEPTH);
  assign take    = !out_valid_q || bus.out_ready;
  assign issue   = take && (|rdy_vec);
  assign alloc   = bus.in_valid && bus.in_ready;
  assign busy_d  = (busy_q & ~(issue ? sel_oh : '0)) | (alloc ? free_oh : '0);
  assign count_d = count_q + IDX_W'(alloc) - IDX_W'(issue);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0; op_q <= '0; pc_q <= '0; vi_q <= '0; vj_q <= '0; imm_q <= '0;
      rd_q <= '0; qi_q <= '0; qj_q <= '0; older_q <= '0; count_q <= '0;
      out_valid_q <= 1'b0; out_op_q <= OP_NOP; out_rd_q <= '0;
      out_pc_q <= '0; out_vi_q <= '0; out_vj_q <= '0; out_imm_q <= '0;
    end else if (rdy) begin
      if (rollback_signal) begin
        busy_q      <= '0;
        count_q     <= '0;
        out_valid_q <= 1'b0;
        out_op_q    <= OP_NOP;
      end else begin
        busy_q  <= busy_d;
        count_q <= count_d;
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy_q[i]) begin
            qi_q[i] <= wqi[i]; vi_q[i] <= wvi[i];
            qj_q[i] <= wqj[i]; vj_q[i] <= wvj[i];
          end
        end
        if (alloc) begin
          op_q[free_idx]  <= bus.in_optype;
          pc_q[free_idx]  <= bus.in_pc;
          rd_q[free_idx]  <= bus.in_rd_alias;
          imm_q[free_idx] <= bus.in_imm;
          qi_q[free_idx]  <= dqi;
          vi_q[free_idx]  <= dvi;
          qj_q[free_idx]  <= dqj;
          vj_q[free_idx]  <= dvj;
          older_q[free_idx] <= '0;
          for (int j = 0; j < RS_DEPTH; j++) older_q[j][free_idx] <= busy_q[j];
        end
        if (issue) begin
          out_valid_q <= 1'b1;
          out_op_q    <= op_q[sel_idx];
          out_rd_q    <= rd_q[sel_idx];
          out_pc_q    <= pc_q[sel_idx];
          out_vi_q    <= vi_q[sel_idx];
          out_vj_q    <= vj_q[sel_idx];
          out_imm_q   <= imm_q[sel_idx];
        end else if (take) begin
          out_valid_q <= 1'b0;
          out_op_q    <= OP_NOP;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_optype = out_op_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.out_Vi     = out_vi_q;
  assign bus.out_Vj     = out_vj_q;
  assign bus.out_imm    = out_imm_q;
  assign count          = count_q;
endmodule

// File: tb/tb_rs_age_issue_queue.sv
// Bench for rs_age_issue_queue: bypass vector table plus flush/freeze/back-pressure sequences.
module tb_rs_age_issue_queue;
  localparam int RS_DEPTH = 16, IDX_W = 5, ROB_W = 4, DATA_W = 32, OP_W = 6, CDB_PORTS = 2;

  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, rollback_signal = 1'b0;
  logic [IDX_W-1:0] count;

  rs_age_issue_queue_if #(.ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)) bus();

  rs_age_issue_queue #(.RS_DEPTH(RS_DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W), .DATA_W(DATA_W),
                       .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal), .bus(bus), .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] pc, vi, vj;
  } exp_t;

  typedef struct {
    logic [ROB_W-1:0]  qi, qj;
    logic [DATA_W-1:0] vi, vj;
    logic [1:0]        cv;
    logic [ROB_W-1:0]  a0, a1;
    logic [DATA_W-1:0] d0, d1, evi, evj;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   n_chk = 0, n_fail = 0;

  function automatic logic [OP_W-1:0] op_of(input logic [DATA_W-1:0] pc);
    return pc[OP_W-1:0] | OP_W'(1);
  endfunction
  function automatic logic [DATA_W-1:0] imm_of(input logic [DATA_W-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [ROB_W-1:0] rd_of(input logic [DATA_W-1:0] pc);
    return pc[ROB_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [ROB_W-1:0] a0, a1,
                         input logic [DATA_W-1:0] d0, d1);
    bus.cdb_valid = v;
    bus.cdb_alias = {a1, a0};
    bus.cdb_data  = {d1, d0};
  endtask

  task automatic drive_op(input logic [ROB_W-1:0] qi, qj, input logic [DATA_W-1:0] vi, vj, pc);
    bus.in_valid    = 1'b1;
    bus.in_Qi       = qi;
    bus.in_Qj       = qj;
    bus.in_Vi       = vi;
    bus.in_Vj       = vj;
    bus.in_pc       = pc;
    bus.in_optype   = op_of(pc);
    bus.in_imm      = imm_of(pc);
    bus.in_rd_alias = rd_of(pc);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    set_cdb(2'b00, '0, '0, '0, '0);
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] pc, vi, vj);
    exp_t e;
    e.pc = pc; e.vi = vi; e.vj = vj;
    sb.push_back(e);
  endtask

  // Handshake observed mid-cycle; the issued op retires at the next rising edge.
  always @(negedge clk) begin
    if (rst && rdy && !rollback_signal && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", bus.out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_pc",  bus.out_pc, e.pc);
        chk("issue_Vi",  bus.out_Vi, e.vi);
        chk("issue_Vj",  bus.out_Vj, e.vj);
        chk("issue_imm", bus.out_imm, imm_of(e.pc));
        chk("issue_op",  32'(bus.out_optype), 32'(op_of(e.pc)));
        chk("issue_rd",  32'(bus.out_rd), 32'(rd_of(e.pc)));
      end
    end
  end

  initial begin
    vt[0] = '{qi:0, qj:0, vi:32'h11,  vj:32'h22, cv:2'b00, a0:0, a1:0, d0:0, d1:0,
              evi:32'h11, evj:32'h22};
    vt[1] = '{qi:0, qj:5, vi:32'hAA,  vj:32'h0,  cv:2'b01, a0:5, a1:0, d0:32'h1234, d1:0,
              evi:32'hAA, evj:32'h1234};
    vt[2] = '{qi:6, qj:0, vi:32'h0,   vj:32'h33, cv:2'b10, a0:0, a1:6, d0:0, d1:32'hCAFE,
              evi:32'hCAFE, evj:32'h33};
    vt[3] = '{qi:2, qj:2, vi:32'h0,   vj:32'h0,  cv:2'b11, a0:2, a1:2, d0:32'h1111, d1:32'h2222,
              evi:32'h1111, evj:32'h1111};
    vt[4] = '{qi:3, qj:4, vi:32'h0,   vj:32'h0,  cv:2'b11, a0:4, a1:3, d0:32'h4444, d1:32'h3333,
              evi:32'h3333, evj:32'h4444};
    vt[5] = '{qi:0, qj:0, vi:32'h55,  vj:32'h66, cv:2'b11, a0:0, a1:0, d0:32'hBAD, d1:32'hBAD,
              evi:32'h55, evj:32'h66};

    idle();
    bus.in_Qi = '0; bus.in_Qj = '0; bus.in_Vi = '0; bus.in_Vj = '0; bus.in_pc = '0;
    bus.in_optype = '0; bus.in_imm = '0; bus.in_rd_alias = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_optype", bus.out_optype, 0);
    rst = 1'b1;
    step();

    // Single-op bypass table: each op must issue exactly one edge after dispatch.
    for (int k = 0; k < 6; k++) begin
      drive_op(vt[k].qi, vt[k].qj, vt[k].vi, vt[k].vj, 32'h100 + k);
      set_cdb(vt[k].cv, vt[k].a0, vt[k].a1, vt[k].d0, vt[k].d1);
      push_exp(32'h100 + k, vt[k].evi, vt[k].evj);
      step();
      idle();
      chk("vec_count_after_dispatch", count, 1);
      chk("vec_not_yet_valid", bus.out_valid, 0);
      step();
      chk("vec_issue_valid", bus.out_valid, 1);
      chk("vec_count_after_issue", count, 0);
    end
    step();
    chk("vec_drained_nop", bus.out_optype, 0);

    // Fill, reject 17th, wake all via port 1, drain in dispatch order.
    for (int i = 0; i < RS_DEPTH; i++) begin
      drive_op(3, 0, 32'h0, 32'(i), 32'h200 + i);
      push_exp(32'h200 + i, 32'hDEADBEEF, 32'(i));
      step();
    end
    chk("full_count", count, 16);
    chk("full_in_ready", bus.in_ready, 0);
    drive_op(0, 0, 32'h9, 32'h9, 32'h2FF);
    step();
    chk("full_17th_ignored", count, 16);
    idle();
    set_cdb(2'b10, 0, 3, 0, 32'hDEADBEEF);
    step();
    idle();
    chk("wake_not_yet_valid", bus.out_valid, 0);
    chk("full_issue_in_ready", bus.in_ready, 0);
    for (int k = 0; k < RS_DEPTH; k++) begin
      step();
      chk("drain_consecutive", bus.out_valid, 1);
      if (k == 0) begin
        chk("after_first_issue_count", count, 15);
        chk("after_first_issue_in_ready", bus.in_ready, 1);
      end
    end
    step();
    chk("drain_done_valid", bus.out_valid, 0);
    chk("drain_done_count", count, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Back-pressure: output held bit-stable, then next oldest follows.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_op(0, 0, 32'h300 + i, 32'h310 + i, 32'h330 + i);
      push_exp(32'h330 + i, 32'h300 + i, 32'h310 + i);
      step();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc_held", bus.out_pc, 32'h330);
      chk("bp_vi_held", bus.out_Vi, 32'h300);
      chk("bp_count", count, 2);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_next_pc", bus.out_pc, 32'h331);
    step();
    chk("bp_last_pc", bus.out_pc, 32'h332);
    step();
    chk("bp_done_count", count, 0);

    // Rollback with 8 waiting entries and a stalled output.
    bus.out_ready = 1'b0;
    drive_op(0, 0, 32'h50, 32'h51, 32'h500);
    step();
    for (int i = 0; i < 8; i++) begin
      drive_op(7, 0, 32'h0, 32'h0, 32'h510 + i);
      step();
    end
    idle();
    chk("rb_pre_count", count, 8);
    chk("rb_pre_valid", bus.out_valid, 1);
    rollback_signal = 1'b1;
    drive_op(0, 0, 32'h1, 32'h2, 32'h5FF);
    set_cdb(2'b01, 7, 0, 32'h77, 0);
    step();
    rollback_signal = 1'b0;
    idle();
    sb.delete();
    chk("rb_count", count, 0);
    chk("rb_valid", bus.out_valid, 0);
    chk("rb_in_ready", bus.in_ready, 1);
    chk("rb_optype", bus.out_optype, 0);
    bus.out_ready = 1'b1;
    set_cdb(2'b01, 7, 0, 32'h77, 0);
    repeat (3) step();
    idle();
    chk("rb_after_valid", bus.out_valid, 0);
    chk("rb_after_count", count, 0);

    // Freeze: CDB matches and dispatch ignored while rdy is low.
    drive_op(9, 0, 32'h0, 32'h60, 32'h600);
    step();
    drive_op(9, 0, 32'h0, 32'h61, 32'h601);
    step();
    idle();
    rdy = 1'b0;
    set_cdb(2'b01, 9, 0, 32'h9999, 0);
    drive_op(0, 0, 32'h1, 32'h1, 32'h6FF);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("frz_count", count, 2);
      chk("frz_valid", bus.out_valid, 0);
    end
    rdy = 1'b1;
    idle();
    step();
    chk("frz_resume_not_woken", bus.out_valid, 0);
    chk("frz_resume_count", count, 2);
    push_exp(32'h600, 32'h9999, 32'h60);
    push_exp(32'h601, 32'h9999, 32'h61);
    set_cdb(2'b10, 0, 9, 0, 32'h9999);
    step();
    idle();
    step();
    chk("frz_wake_issue", bus.out_valid, 1);
    repeat (2) step();
    chk("frz_done_count", count, 0);
    chk("frz_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-traffic.
    bus.out_ready = 1'b0;
    drive_op(0, 0, 32'h70, 32'h71, 32'h700);
    step();
    drive_op(10, 0, 32'h0, 32'h0, 32'h701);
    step();
    drive_op(0, 0, 32'h72, 32'h73, 32'h702);
    step();
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    sb.delete();
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_cdb(2'b01, 10, 0, 32'hAB, 0);
    repeat (3) step();
    idle();
    chk("arst_after_valid", bus.out_valid, 0);
    chk("arst_after_count", count, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
